irq_encoder_32_5: RTL and testbench
===================================

// Module: irq_encoder_32_5
// PURPOSE
//  Sequential 32-to-5 request encoder: inverse of the 5-to-32 register-select decoder.
//  - Captures up to 32 one-cycle request strobes into a pending register.
//  - Presents one pending request at a time as a 5-bit index with a valid/ack handshake.
//  - Sits between event sources (writeback, exceptions, peripherals) and the control logic that services them by index.
// PARAMETERS
//  none; width is fixed at 32 requests / 5-bit index.
// PORTS
//  clock     in   1   rising-edge clock
//  reset_n   in   1   synchronous, active-low reset
//  req       in   32  request strobes; bit i high for a cycle = event i
//  ack       in   1   consumer accepts the presented index (sampled only while valid=1)
//  idx       out  5   index of the granted request
//  valid     out  1   idx is valid and held stable until acked
//  pending   out  32  current pending register, for debug/status
//  overrun   out  1   one-cycle pulse: a req bit hit an already-pending bit
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge): pending=0, idx=0, valid=0, overrun=0, state=IDLE.
//  - Reset has priority over every other event, including a mid-handshake reset.
//  - Pending update each edge: pending <= (pending & ~clr) | req.
//    - clr = onehot(idx) when valid & ack, else 0.
//    - A req on the bit being cleared in the same cycle wins: the bit stays set.
//  - Overrun: overrun <= |(req & pending & ~clr), registered one cycle later.
//    - The duplicate event is merged; no count is kept.
//  - FSM, two states:
//    - IDLE: if pending != 0, load idx = select(pending), set valid <= 1, go to HOLD. Otherwise valid stays 0.
//    - HOLD: idx is frozen; new requests never preempt it. On ack, valid <= 0, clear bit idx, go to IDLE.
//  - ack while valid=0 is ignored.
//  - Latency:
//    - req at edge t is in pending after edge t; valid rises after edge t+1 (2 cycles).
//    - Back-to-back grants occur at most every 2 cycles: ack edge, then IDLE reload edge.
//  - select(): fixed priority, lowest set bit index wins (bit 0 highest).
//  - idx retains its last value while valid=0.
// CONFIGURATION
//  IRQ_ENCODER_ROUND_ROBIN_EN:
//  - Defined:
//    - A 5-bit last-grant pointer (reset 5'd31) updates to idx on each acked grant.
//    - select() searches from last+1 upward, wrapping from 31 to 0.
//    - The first grant after reset therefore favours bit 0.
//  - Undefined: fixed lowest-index priority as above; no pointer register exists.
// TESTING
//  1. Hold reset_n=0 for 2 cycles with req=32'hFFFF_FFFF
//     -> valid=0, idx=0, pending=0, overrun=0.
//  2. Pulse req=32'h0000_0008 for 1 cycle
//     -> valid=1 and idx=5'd3 two cycles later.
//     -> Ack -> next cycle valid=0, pending=0.
//  3. Pulse req=32'h0000_0028, ack each grant
//     -> idx=3 then idx=5, pending=0 at the end.
//     -> Same result with the EN macro defined, from reset.
//  4. While idx=3 is held, pulse req=32'h0000_0008 in the same cycle as ack
//     -> bit 3 stays pending, re-granted with idx=3, overrun=0.
//     -> req bit 8 twice before service -> one overrun pulse.
//  5. Round-robin (macro defined): hold req=32'h8000_0001 every cycle, ack each grant
//     -> idx sequence 0,31,0,31.
//     -> Same stimulus with macro undefined -> 0,0,0.
//  6. Drop reset_n=0 in HOLD with pending=32'h0000_0300
//     -> next cycle valid=0, pending=0, and no grant after release.

Source files
------------

// File: rtl/irq_encoder_32_5_if.sv
// Request/grant bundle between event sources, the encoder and the consumer
// that services requests by index. The encoder side uses the slave modport.
interface irq_encoder_32_5_if;
    logic [31:0] req;      // one-cycle request strobes, bit i = event i
    logic        ack;      // consumer accepts the presented index
    logic [4:0]  idx;      // index of the granted request
    logic        valid;    // idx valid, held stable until acked
    logic [31:0] pending;  // pending register, for debug/status
    logic        overrun;  // one-cycle pulse: request hit an already-pending bit

    modport master (
        output req,
        output ack,
        input  idx,
        input  valid,
        input  pending,
        input  overrun
    );

    modport slave (
        input  req,
        input  ack,
        output idx,
        output valid,
        output pending,
        output overrun
    );
endinterface

// File: rtl/irq_encoder_32_5.sv
// Sequential 32-to-5 request encoder. Request strobes are merged into a
// pending register; one pending request at a time is presented as a 5-bit
// index with a valid/ack handshake.
//
// Optional feature: define IRQ_ENCODER_ROUND_ROBIN_EN to replace the fixed
// lowest-index priority with a round-robin search that starts just above the
// last acked grant (pointer resets to 31, so bit 0 is favoured first).
module irq_encoder_32_5 (
    input  logic             clock,
    input  logic             reset_n,
    irq_encoder_32_5_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [31:0] pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic [31:0] clr;
    logic [4:0]  sel_idx;

    // Index of the lowest set bit; 0 when the vector is empty (never used then).
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
    logic [4:0]  last_q, last_d;
    logic [4:0]  start;
    logic [63:0] doubled;

    // Rotate pending so bit (last+1) lands at position 0, pick the lowest
    // set bit there, then rotate the answer back; 5-bit adds wrap 31 -> 0.
    assign start   = last_q + 5'd1;
    assign doubled = {pending_q, pending_q} >> start;
    assign sel_idx = lowest_set(doubled[31:0]) + start;
`else
    assign sel_idx = lowest_set(pending_q);
`endif

    // Next-state, handshake and pending-register update logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        clr     = '0;

        if (valid_q && bus.ack) clr = 32'b1 << idx_q;

        // A request on the bit being cleared this cycle wins: it stays set.
        pending_d = (pending_q & ~clr) | bus.req;
        overrun_d = |(bus.req & pending_q & ~clr);

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // idx is frozen here; new requests never preempt it.
                if (bus.ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
                    last_d  = idx_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset taking priority.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            overrun_q <= 1'b0;
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
            last_q    <= 5'd31;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.idx     = idx_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_encoder_32_5.sv
// Self-checking bench for irq_encoder_32_5: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model of
// the pending set and the current grant.
module tb_irq_encoder_32_5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    irq_encoder_32_5_if bus();

    irq_encoder_32_5 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a set of pending events, the event currently granted
    // (-1 when none), the last presented index and the last acked event.
    bit m_pend[32];
    int m_grant = -1;
    int m_idx   = 0;
    int m_last  = 31;
    bit m_over  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit model_any();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Which pending event gets the next grant.
    function automatic int model_pick();
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
        for (int k = 1; k <= 32; k++) begin
            if (m_pend[(m_last + k) % 32]) return (m_last + k) % 32;
        end
`else
        for (int i = 0; i < 32; i++) if (m_pend[i]) return i;
`endif
        return -1;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input logic rn, input logic [31:0] r, input logic a);
        bit acked;
        bit had_any;
        int pick;
        if (!rn) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_grant = -1;
            m_idx   = 0;
            m_last  = 31;
            m_over  = 1'b0;
            return;
        end
        acked   = (m_grant >= 0) && a;
        had_any = model_any();
        pick    = model_pick();
        m_over  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bit cleared;
            cleared = acked && (i == m_grant);
            if (r[i] && m_pend[i] && !cleared) m_over = 1'b1;
            m_pend[i] = (m_pend[i] && !cleared) || r[i];
        end
        if (m_grant < 0) begin
            if (had_any) begin
                m_grant = pick;
                m_idx   = pick;
            end
        end else if (acked) begin
            m_last  = m_grant;
            m_grant = -1;
        end
    endtask

    // One clock cycle: drive inputs, take the edge, compare all outputs.
    task automatic cycle(input logic rn, input logic [31:0] r, input logic a);
        reset_n = rn;
        bus.req = r;
        bus.ack = a;
        @(posedge clock);
        model_step(rn, r, a);
        #1;
        check("valid",   32'(bus.valid),   32'(m_grant >= 0));
        check("idx",     32'(bus.idx),     32'(m_idx));
        check("pending", bus.pending,      model_pending());
        check("overrun", 32'(bus.overrun), 32'(m_over));
    endtask

    int grants[$];
    int exp_rr[4];

    initial begin
        bus.req = '0;
        bus.ack = 1'b0;

        // 1: reset held with all requests asserted
        cycle(1'b0, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b0, 32'hFFFF_FFFF, 1'b0);
        check("rst_valid",   32'(bus.valid),   32'd0);
        check("rst_idx",     32'(bus.idx),     32'd0);
        check("rst_pending", bus.pending,      32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);

        // 2: single request, two-cycle latency, ack clears it
        cycle(1'b1, 32'h0000_0008, 1'b0);
        check("t2_not_yet", 32'(bus.valid), 32'd0);
        cycle(1'b1, 32'h0, 1'b0);
        check("t2_valid", 32'(bus.valid), 32'd1);
        check("t2_idx",   32'(bus.idx),   32'd3);
        cycle(1'b1, 32'h0, 1'b1);
        check("t2_ack_valid",   32'(bus.valid), 32'd0);
        check("t2_ack_pending", bus.pending,    32'd0);

        // 3: two requests from reset, served 3 then 5
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0028, 1'b0);
        cycle(1'b1, 32'h0, 1'b0);
        check("t3_first", 32'(bus.idx), 32'd3);
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b1, 32'h0, 1'b0);
        check("t3_second", 32'(bus.idx), 32'd5);
        cycle(1'b1, 32'h0, 1'b1);
        check("t3_pending", bus.pending, 32'd0);

        // 4: re-request on the bit being acked, then a duplicate request
        cycle(1'b1, 32'h0000_0008, 1'b0);
        cycle(1'b1, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0008, 1'b1);
        check("t4_kept",    bus.pending,      32'h0000_0008);
        check("t4_no_over", 32'(bus.overrun), 32'd0);
        cycle(1'b1, 32'h0, 1'b0);
        check("t4_regrant", 32'(bus.idx), 32'd3);
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b1, 32'h0000_0100, 1'b0);
        cycle(1'b1, 32'h0000_0100, 1'b0);
        check("t4_overrun", 32'(bus.overrun), 32'd1);
        cycle(1'b1, 32'h0, 1'b0);
        check("t4_over_pulse", 32'(bus.overrun), 32'd0);
        cycle(1'b1, 32'h0, 1'b1);

        // 5: requests 0 and 31 held every cycle, every grant acked
        cycle(1'b0, 32'h0, 1'b0);
`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
        exp_rr = '{0, 31, 0, 31};
`else
        exp_rr = '{0, 0, 0, 0};
`endif
        grants.delete();
        for (int c = 0; c < 12 && grants.size() < 4; c++) begin
            cycle(1'b1, 32'h8000_0001, 1'b1);
            if (bus.valid) grants.push_back(int'(bus.idx));
        end
        check("t5_count", 32'(grants.size()), 32'd4);
        for (int g = 0; g < grants.size() && g < 4; g++)
            check($sformatf("t5_grant%0d", g), 32'(grants[g]), 32'(exp_rr[g]));

        // 6: reset in the middle of a handshake
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0300, 1'b0);
        cycle(1'b1, 32'h0, 1'b0);
        check("t6_hold", 32'(bus.valid), 32'd1);
        cycle(1'b0, 32'h0, 1'b0);
        check("t6_valid",   32'(bus.valid), 32'd0);
        check("t6_pending", bus.pending,    32'd0);
        cycle(1'b1, 32'h0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0);
        check("t6_no_grant", 32'(bus.valid), 32'd0);

        // Randomized traffic: sparse requests, random acks, rare resets
        for (int n = 0; n < 500; n++) begin
            logic [31:0] r;
            logic        a;
            logic        rn;
            r  = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            a  = 1'($urandom_range(0, 1));
            rn = ($urandom_range(0, 60) != 0);
            cycle(rn, r, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
